// File: rtl/imc22_mem_pkg.sv
// imc22_mem_pkg: geometry constants and FSM states for the scratch SRAM responder
package imc22_mem_pkg;
  localparam int SRAM_BYTES = 1024;
  localparam int RD_BYTES = 16;
  localparam int ADDR_W = $clog2(SRAM_BYTES);
  localparam int ROWS = SRAM_BYTES / RD_BYTES;
  localparam int ROW_W = $clog2(ROWS);
  localparam int LANE_W = $clog2(RD_BYTES);
  typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/imc22_sram_bank.sv
// imc22_sram_bank: one byte-wide bank, synchronous read-first read port plus a write port
module imc22_sram_bank
  import imc22_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ROW_W-1:0] wa,
  input  logic [7:0]       wd,
  input  logic             re,
  input  logic [ROW_W-1:0] ra,
  output logic [7:0]       q
);
  logic [7:0] mem [ROWS];
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  // q holds between reads so the assembled read word stays stable
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (re) q <= mem[ra];
endmodule

// File: rtl/imc22_sram_resp.sv
// imc22_sram_resp: 1 KB banked scratch SRAM with unaligned 16-byte reads, byte writes and zero-fill init
module imc22_sram_resp
  import imc22_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [8*RD_BYTES-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [7:0]            wr_data,
  output logic                  ready
);
  state_t state;
  logic [ROW_W-1:0] row;
  logic [LANE_W-1:0] s_q;
  logic [7:0] q [RD_BYTES];
  logic init, rd_fire;
  assign init = state == INIT;
  assign rd_fire = rd_req & ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INIT;
      row <= '0;
      ready <= 1'b0;
      rd_valid <= 1'b0;
      s_q <= '0;
    end else begin
      ready <= state == RUN;
      rd_valid <= rd_fire;
      if (rd_fire) s_q <= rd_addr[LANE_W-1:0];
      if (init) begin
        row <= row + ROW_W'(1);
        if (&row) state <= RUN;
      end
    end
  // banks below the start lane belong to the next row; the 6-bit add wraps the top of memory
  for (genvar b = 0; b < RD_BYTES; b++) begin : g_bank
    logic [ROW_W-1:0] ra;
    assign ra = (LANE_W'(b) >= rd_addr[LANE_W-1:0]) ? rd_addr[ADDR_W-1:LANE_W]
                                                     : rd_addr[ADDR_W-1:LANE_W] + ROW_W'(1);
    imc22_sram_bank u_bank (
      .clk,
      .rst,
      .we(init | (wr_en & ready & (wr_addr[LANE_W-1:0] == LANE_W'(b)))),
      .wa(init ? row : wr_addr[ADDR_W-1:LANE_W]),
      .wd(init ? 8'h00 : wr_data),
      .re(rd_fire),
      .ra,
      .q(q[b])
    );
    assign rd_data[8*b +: 8] = q[s_q + LANE_W'(b)];
  end
endmodule

// File: tb/tb_imc22_sram_resp.sv
// tb_imc22_sram_resp: directed stimulus with a queue-based scoreboard on rd_valid
module tb_imc22_sram_resp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_req = 1'b1;
  logic [9:0] rd_addr = '0;
  logic [127:0] rd_data;
  logic rd_valid;
  logic wr_en = 1'b0;
  logic [9:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic ready;
  int tests = 0;
  int fails = 0;
  logic [127:0] exp_q [$];
  logic [127:0] got;

  imc22_sram_resp dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rd_valid: got data %h expected no response", rd_data);
      end else begin
        got = exp_q.pop_front();
        chk("rd_data", rd_data, got);
      end
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [127:0] e);
    rd_req = 1'b1;
    rd_addr = a;
    exp_q.push_back(e);
    tick();
    rd_req = 1'b0;
  endtask

  // rst has just been released right after an edge; rd_req is held high throughout
  task automatic init_phase(input logic [9:0] a);
    rd_addr = a;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 1 || i == 63 || i == 64) begin
        chk("init_ready", {127'd0, ready}, 128'd0);
        chk("init_valid", {127'd0, rd_valid}, 128'd0);
      end
    end
    tick();
    wr_en = 1'b0;
    chk("ready_at_65", {127'd0, ready}, 128'd1);
    chk("valid_at_65", {127'd0, rd_valid}, 128'd0);
    exp_q.push_back(128'd0);
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    wr_en = 1'b1;
    wr_addr = 10'h050;
    wr_data = 8'h77;
    repeat (3) @(posedge clk);
    chk("reset_ready", {127'd0, ready}, 128'd0);
    chk("reset_rd_data", rd_data, 128'd0);
    #1 rst = 1'b0;
    init_phase(10'h000);
    rd(10'h050, 128'd0);
    for (int i = 0; i < 16; i++) wr(10'(i), 8'(i));
    rd(10'h000, 128'h0F0E0D0C0B0A09080706050403020100);
    for (int i = 0; i < 8; i++) wr(10'h3F8 + 10'(i), 8'hA0 + 8'(i));
    for (int i = 0; i < 8; i++) wr(10'(i), 8'hB0 + 8'(i));
    rd(10'h3F8, 128'hB7B6B5B4B3B2B1B0A7A6A5A4A3A2A1A0);
    rd(10'h3FF, 128'h0E0D0C0B0A0908B7B6B5B4B3B2B1B0A7);
    for (int i = 0; i < 32; i++) wr(10'h100 + 10'(i), 8'(i));
    rd(10'h105, 128'h14131211100F0E0D0C0B0A0908070605);
    tick();
    chk("hold_valid", {127'd0, rd_valid}, 128'd0);
    chk("hold_data", rd_data, 128'h14131211100F0E0D0C0B0A0908070605);
    rd_req = 1'b1;
    rd_addr = 10'h100;
    exp_q.push_back(128'h0F0E0D0C0B0A09080706050403020100);
    tick();
    rd_addr = 10'h110;
    exp_q.push_back(128'h1F1E1D1C1B1A19181716151413121110);
    tick();
    rd_req = 1'b0;
    wr_en = 1'b1;
    wr_addr = 10'h020;
    wr_data = 8'h5A;
    rd_req = 1'b1;
    rd_addr = 10'h020;
    exp_q.push_back(128'd0);
    tick();
    wr_en = 1'b0;
    exp_q.push_back(128'h5A);
    tick();
    rd_req = 1'b0;
    wr(10'h040, 8'hFF);
    rd_req = 1'b1;
    rd_addr = 10'h040;
    exp_q.push_back(128'hFF);
    tick();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_valid_drop", {127'd0, rd_valid}, 128'd0);
    chk("rst_ready_drop", {127'd0, ready}, 128'd0);
    tick();
    rst = 1'b0;
    init_phase(10'h040);
    repeat (3) tick();
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imc22_sram_resp.md
Name: imc22_sram_resp

Overview:
- Shared 1 KB scratch SRAM responder; the target side of the NPU's 16-byte-wide read strobe interface (10-bit byte address, 128-bit data).
- Also accepts byte writes from the CPU/UART loader.
- Built as 16 byte-banks, so unaligned and wrap-around 16-byte reads complete in one access.
- Zero-fills itself after reset before accepting traffic.

Parameters:
- SRAM_BYTES, 1024, total capacity in bytes (power of two)
- RD_BYTES, 16, bytes per read beat; equals the bank count
- ADDR_W, 10, byte address width, log2(SRAM_BYTES)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_req  in  1  read strobe, sampled each cycle ready=1
- rd_addr  in  ADDR_W  start byte address of the read
- rd_data  out  8*RD_BYTES  byte k = mem[(rd_addr+k) mod SRAM_BYTES] at bits [8k+7:8k]
- rd_valid  out  1  one-cycle pulse, rd_data updated this cycle
- wr_en  in  1  byte write strobe
- wr_addr  in  ADDR_W  byte address to write
- wr_data  in  8  write byte
- ready  out  1  high once init is complete; low during INIT

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: rd_data=0, rd_valid=0, ready=0, FSM=INIT, init row counter=0.
- Storage: bank b holds bytes whose addr[3:0]=b; row = addr[9:4]; 64 rows × 16 banks.
- FSM INIT:
  - Each cycle, write 0 to the current row in all 16 banks, then increment the row counter.
  - After row 63 is written, go to RUN.
  - ready rises on the cycle after the row 63 write: the 65th rising edge after rst deasserts.
  - rd_req and wr_en are ignored in INIT: no rd_valid, no memory change.
- FSM RUN: ready=1. The FSM stays in RUN until rst.
- Reset mid-operation (any state): asynchronously return to INIT; rd_valid=0; the full 64-row clear restarts.
- Read path, fixed 1-cycle latency:
  - rd_req=1 at edge N → rd_valid=1 and new rd_data after edge N+1.
  - rd_valid falls the next cycle unless rd_req is held.
- Back-to-back reads are supported: one read per cycle, each returned one cycle later.
- rd_data holds its last value while rd_valid=0.
- Per-lane read address: let s=rd_addr[3:0], r=rd_addr[9:4].
  - Bank b reads row r when b>=s, otherwise row (r+1) mod 64.
  - Lane k takes bank (s+k) mod 16.
- Wrap-around: addresses exceed 0x3FF modulo 1024. Example: rd_addr=0x3F8 returns bytes 0x3F8..0x3FF then 0x000..0x007.
- Write path: mem[wr_addr] <= wr_data on the edge where wr_en=1 and ready=1. Visible to reads sampled on later edges.
- Same-cycle read and write:
  - The read is read-first: bytes covered by the read return the pre-write value.
  - The write still commits.
  - A read on the next cycle sees the new value.
- Both ports may be active every cycle; the block applies no backpressure.

Decomposition:
- Package imc22_mem_pkg:
  - SRAM_BYTES, RD_BYTES, ADDR_W constants
  - ROWS=SRAM_BYTES/RD_BYTES and ROW_W=log2(ROWS)
  - FSM state enum {INIT, RUN}
- Sub-module imc22_sram_bank, instantiated 16×:
  - 64×8 array; one synchronous read port and one write port, read-first on collision
  - Shared by the init clear (all banks) and byte writes (one bank selected by wr_addr[3:0])
- Top level contains the FSM, per-bank row/lane rotation, and the output register.

Test Plan:
- Release rst at cycle 0 with rd_req held 1 → ready=0 and rd_valid=0 for 64 cycles; ready=1 at cycle 65; first rd_valid one cycle after ready, rd_data=0.
- Write bytes 0x00..0x0F to addr 0x000..0x00F, then rd_req addr 0x000 → next cycle rd_valid=1, rd_data=0x0F0E...0100.
- Write mem[0x3F8+i]=0xA0+i and mem[i]=0xB0+i (i=0..7), then read 0x3F8 → rd_data low 8 bytes 0xA0..0xA7, high 8 bytes 0xB0..0xB7.
- Unaligned read at 0x105 after writing mem[a]=a[7:0] over 0x100..0x11F → lanes 0..15 = 0x05..0x14.
- Same cycle: wr_en addr 0x020 data 0x5A plus rd_req addr 0x020 → rd_data byte0=0x00; repeat read next cycle → byte0=0x5A.
- Reset during run: write 0xFF to 0x040, assert rst for 1 cycle mid back-to-back reads → rd_valid drops immediately; ready low for 64 cycles; read of 0x040 afterwards returns 0x00.
